aes_out_serializer: RTL and testbench
=====================================

AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 Parameter MSW_FIRST, default 1, word order: 1 = bits [127:96] read first; 0 = bits [31:0] read first.
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 load  input  1  one-cycle strobe; data_in holds a valid 128-bit AES result.
REQ-005 data_in  input  128  AES result block (ciphertext/plaintext).
REQ-006 rd  input  1  host read strobe; requests next 32-bit word.
REQ-007 clr_ovr  input  1  clears the overrun flag.
REQ-008 bus_word  output  32  word to the downstream 32-bit tri-state buffer data input.
REQ-009 cs  output  1  chip-select to the tri-state buffer; 1 = drive bus_word onto shared bus.
REQ-010 busy  output  1  high while a captured block has unread words.
REQ-011 overrun  output  1  sticky flag: a load was rejected.

Function
REQ-012 FSM states IDLE, HOLD, DRIVE; busy = (state != IDLE).
REQ-013 Internal 128-bit holding register and 2-bit word index idx (0..3).
REQ-014 IDLE: load=1 -> capture data_in, idx=0, next state HOLD; rd ignored.
REQ-015 HOLD: rd=1 -> next cycle state DRIVE, cs=1, bus_word = word[idx]; rd=0 -> stay HOLD, cs=0.
REQ-016 Word mapping, MSW_FIRST=1: word[i] = hold[127-32i -: 32]; MSW_FIRST=0: word[i] = hold[32i +: 32].
REQ-017 Read latency: exactly 1 cycle from rd sampled high to cs=1 with the word.
REQ-018 cs high for exactly one cycle per accepted rd; idx increments at the end of each DRIVE cycle.
REQ-019 DRIVE with idx<3 and rd=1 -> stays DRIVE, next word presented the following cycle (back-to-back reads, one word per clock).
REQ-020 DRIVE with idx<3 and rd=0 -> HOLD.
REQ-021 DRIVE with idx=3 (fourth word) -> IDLE next cycle; rd in that cycle ignored.
REQ-022 bus_word = 32'h0 whenever cs=0; never changes while cs=1 within a cycle.
REQ-023 load while busy=1 -> block not captured, overrun set to 1 next cycle, state/idx/hold unchanged.
REQ-024 Exception: load in the DRIVE cycle with idx=3 is accepted -> capture data_in, idx=0, next state HOLD, overrun unchanged.
REQ-025 overrun cleared by clr_ovr=1; if clr_ovr and a rejected load coincide, overrun = 1.
REQ-026 rd and load both high in IDLE -> load accepted, rd ignored (no cs next cycle).
REQ-027 idx never wraps in DRIVE; after word 3 the block returns to IDLE and rd is ignored until the next load.

Reset
REQ-028 rst_n=0 forces immediately, independent of clk: state=IDLE, idx=0, hold=0, cs=0, bus_word=0, busy=0, overrun=0.
REQ-029 Reset mid-transfer discards the block; no further cs pulses until a new load after rst_n returns high.
REQ-030 Inputs ignored while rst_n=0; first active edge after deassertion evaluates from IDLE.

Verification
REQ-031 MSW_FIRST=1, load 0x00112233_44556677_8899AABB_CCDDEEFF, rd held high 4 cycles -> cs=1 for 4 consecutive cycles, bus_word 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, then busy=0.
REQ-032 MSW_FIRST=0, same block, rd pulses spaced 3 cycles -> words 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233, each one cycle after its rd, cs=0 and bus_word=0 between.
REQ-033 After 2 words read, load 0xDEADBEEF_x3 -> overrun=1, remaining words still 0x8899AABB, 0xCCDDEEFF; clr_ovr -> overrun=0.
REQ-034 load of block B in the fourth-word DRIVE cycle -> no overrun, busy stays 1, next 4 reads return block B.
REQ-035 rst_n pulsed low after first word driven -> cs=0, busy=0 immediately; subsequent rd gives no cs.
REQ-036 rd in IDLE and 5th rd after a block -> cs stays 0, bus_word stays 0.

Source files
------------

// File: rtl/aes_out_serializer.sv
// AES result serializer: captures a 128-bit block and hands it
// out one 32-bit word per host read through a tri-state buffer.
module aes_out_serializer #(
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [127:0] data_in,
  input  logic         rd,
  input  logic         clr_ovr,
  output logic [31:0]  bus_word,
  output logic         cs,
  output logic         busy,
  output logic         overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   idx;
  logic [1:0]   idx_nxt;
  logic [127:0] hold;
  logic [127:0] hold_nxt;
  logic         ovr_nxt;
  logic [31:0]  sel;

  // State, word index, holding register and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 2'd0;
      hold    <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      hold    <= hold_nxt;
      overrun <= ovr_nxt;
    end
  end

  // Next-state logic; a rejected load beats a simultaneous clear.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    hold_nxt  = hold;
    ovr_nxt   = overrun;
    if (clr_ovr) ovr_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          hold_nxt  = data_in;
          idx_nxt   = 2'd0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (load) ovr_nxt = 1'b1;
        if (rd) state_nxt = DRIVE;
      end
      DRIVE: begin
        if (idx == 2'd3) begin
          // Last word: the slot is free again, so a load is accepted.
          idx_nxt = 2'd0;
          if (load) begin
            hold_nxt  = data_in;
            state_nxt = HOLD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          idx_nxt   = idx + 2'd1;
          if (load) ovr_nxt = 1'b1;
          state_nxt = rd ? DRIVE : HOLD;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 2'd0;
      end
    endcase
  end

  // Word selection for the current index in the configured order.
  always_comb begin
    sel = '0;
    unique case (idx)
      2'd0: sel = MSW_FIRST ? hold[127:96] : hold[31:0];
      2'd1: sel = MSW_FIRST ? hold[95:64]  : hold[63:32];
      2'd2: sel = MSW_FIRST ? hold[63:32]  : hold[95:64];
      2'd3: sel = MSW_FIRST ? hold[31:0]   : hold[127:96];
      default: sel = '0;
    endcase
  end

  // Outputs decode from registered state only, so they hold steady all cycle.
  always_comb begin
    cs       = (state == DRIVE);
    busy     = (state != IDLE);
    bus_word = cs ? sel : 32'h0;
  end

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer, both word orders.
// Two instances share stimulus; u1 is MSW-first, u0 LSW-first.
module tb_aes_out_serializer;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [127:0] data_in;
  logic         rd;
  logic         clr_ovr;
  logic [31:0]  bw1, bw0;
  logic         cs1, cs0;
  logic         busy1, busy0;
  logic         ovr1, ovr0;

  int total;
  int bad;

  localparam logic [127:0] BLK_A =
    128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B =
    128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] BLK_D =
    128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  aes_out_serializer #(.MSW_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
    .rd(rd), .clr_ovr(clr_ovr), .bus_word(bw1), .cs(cs1),
    .busy(busy1), .overrun(ovr1)
  );

  aes_out_serializer #(.MSW_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
    .rd(rd), .clr_ovr(clr_ovr), .bus_word(bw0), .cs(cs0),
    .busy(busy0), .overrun(ovr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 0; rd = 0; clr_ovr = 0; data_in = '0;
    #12;
    total++;
    if ({cs1, busy1, ovr1, bw1} !== 35'h0) begin
      bad++;
      $display("FAIL reset_u1 got cs=%b busy=%b ovr=%b bw=%h want 0",
               cs1, busy1, ovr1, bw1);
    end
    total++;
    if ({cs0, busy0, ovr0, bw0} !== 35'h0) begin
      bad++;
      $display("FAIL reset_u0 got cs=%b busy=%b ovr=%b bw=%h want 0",
               cs0, busy0, ovr0, bw0);
    end
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle_rd();
    rd = 1'b1;
    step();
    step();
    total++;
    if (cs1 !== 1'b0 || bw1 !== 32'h0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL idle_rd got cs=%b bw=%h busy=%b want 0 0 0",
               cs1, bw1, busy1);
    end
    load = 1'b1; data_in = BLK_A;
    step();
    load = 1'b0; rd = 1'b0;
    total++;
    if (cs1 !== 1'b0 || busy1 !== 1'b1) begin
      bad++;
      $display("FAIL rd_load_idle got cs=%b busy=%b want 0 1",
               cs1, busy1);
    end
    rd = 1'b1;
    repeat (4) step();
    total++;
    if (cs1 !== 1'b1 || bw1 !== 32'hCCDDEEFF) begin
      bad++;
      $display("FAIL fourth_word got cs=%b bw=%h want 1 ccddeeff",
               cs1, bw1);
    end
    step();
    total++;
    if (cs1 !== 1'b0 || bw1 !== 32'h0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL fifth_rd got cs=%b bw=%h busy=%b want 0 0 0",
               cs1, bw1, busy1);
    end
    step();
    rd = 1'b0;
    total++;
    if (cs1 !== 1'b0 || bw1 !== 32'h0) begin
      bad++;
      $display("FAIL sixth_rd got cs=%b bw=%h want 0 0", cs1, bw1);
    end
  endtask

  task automatic test_msw_burst();
    logic [31:0] exp [4];
    exp = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    load = 1'b1; data_in = BLK_A;
    step();
    load = 1'b0;
    total++;
    if (cs1 !== 1'b0 || busy1 !== 1'b1) begin
      bad++;
      $display("FAIL msw_hold got cs=%b busy=%b want 0 1", cs1, busy1);
    end
    rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) rd = 1'b0;
      total++;
      if (cs1 !== 1'b1 || bw1 !== exp[i]) begin
        bad++;
        $display("FAIL msw_word%0d got cs=%b bw=%h want 1 %h",
                 i, cs1, bw1, exp[i]);
      end
    end
    step();
    total++;
    if (busy1 !== 1'b0 || cs1 !== 1'b0 || bw1 !== 32'h0) begin
      bad++;
      $display("FAIL msw_done got busy=%b cs=%b bw=%h want 0 0 0",
               busy1, cs1, bw1);
    end
  endtask

  task automatic test_lsw_spaced();
    logic [31:0] exp [4];
    exp = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    load = 1'b1; data_in = BLK_A;
    step();
    load = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1;
      step();
      rd = 1'b0;
      total++;
      if (cs0 !== 1'b1 || bw0 !== exp[i]) begin
        bad++;
        $display("FAIL lsw_word%0d got cs=%b bw=%h want 1 %h",
                 i, cs0, bw0, exp[i]);
      end
      for (int j = 0; j < 2; j++) begin
        step();
        total++;
        if (cs0 !== 1'b0 || bw0 !== 32'h0) begin
          bad++;
          $display("FAIL lsw_gap%0d_%0d got cs=%b bw=%h want 0 0",
                   i, j, cs0, bw0);
        end
      end
    end
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL lsw_done got busy=%b want 0", busy0);
    end
  endtask

  task automatic test_overrun();
    load = 1'b1; data_in = BLK_A;
    step();
    load = 1'b0; rd = 1'b1;
    step();
    step();
    rd = 1'b0;
    total++;
    if (bw1 !== 32'h44556677) begin
      bad++;
      $display("FAIL ovr_word1 got %h want 44556677", bw1);
    end
    step();
    load = 1'b1; data_in = BLK_D;
    step();
    load = 1'b0;
    total++;
    if (ovr1 !== 1'b1 || busy1 !== 1'b1 || cs1 !== 1'b0) begin
      bad++;
      $display("FAIL ovr_set got ovr=%b busy=%b cs=%b want 1 1 0",
               ovr1, busy1, cs1);
    end
    load = 1'b1; clr_ovr = 1'b1;
    step();
    load = 1'b0; clr_ovr = 1'b0;
    total++;
    if (ovr1 !== 1'b1) begin
      bad++;
      $display("FAIL ovr_clr_coincide got %b want 1", ovr1);
    end
    rd = 1'b1;
    step();
    total++;
    if (cs1 !== 1'b1 || bw1 !== 32'h8899AABB) begin
      bad++;
      $display("FAIL ovr_word2 got cs=%b bw=%h want 1 8899aabb",
               cs1, bw1);
    end
    step();
    rd = 1'b0;
    total++;
    if (cs1 !== 1'b1 || bw1 !== 32'hCCDDEEFF) begin
      bad++;
      $display("FAIL ovr_word3 got cs=%b bw=%h want 1 ccddeeff",
               cs1, bw1);
    end
    step();
    total++;
    if (busy1 !== 1'b0 || ovr1 !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky got busy=%b ovr=%b want 0 1",
               busy1, ovr1);
    end
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    total++;
    if (ovr1 !== 1'b0 || ovr0 !== 1'b0) begin
      bad++;
      $display("FAIL ovr_clear got u1=%b u0=%b want 0 0", ovr1, ovr0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
    load = 1'b1; data_in = BLK_A;
    step();
    load = 1'b0; rd = 1'b1;
    repeat (4) step();
    rd = 1'b0;
    load = 1'b1; data_in = BLK_B;
    step();
    load = 1'b0; data_in = '0;
    total++;
    if (busy1 !== 1'b1 || ovr1 !== 1'b0 || cs1 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept got busy=%b ovr=%b cs=%b want 1 0 0",
               busy1, ovr1, cs1);
    end
    rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) rd = 1'b0;
      total++;
      if (cs1 !== 1'b1 || bw1 !== exp[i]) begin
        bad++;
        $display("FAIL b2b_word%0d got cs=%b bw=%h want 1 %h",
                 i, cs1, bw1, exp[i]);
      end
    end
    step();
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done got busy=%b want 0", busy1);
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; data_in = BLK_A;
    step();
    load = 1'b0; rd = 1'b1;
    step();
    total++;
    if (cs1 !== 1'b1 || bw1 !== 32'h00112233) begin
      bad++;
      $display("FAIL rst_mid_word0 got cs=%b bw=%h want 1 00112233",
               cs1, bw1);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (cs1 !== 1'b0 || busy1 !== 1'b0 || bw1 !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_async got cs=%b busy=%b bw=%h want 0 0 0",
               cs1, busy1, bw1);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (cs1 !== 1'b0 || cs0 !== 1'b0 || busy1 !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_rd%0d got cs1=%b cs0=%b busy=%b want 0",
                 i, cs1, cs0, busy1);
      end
    end
    rd = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_idle_rd();
    test_msw_burst();
    test_lsw_spaced();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
